// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream as SOF/CMD/ARG/CHK. Only checksum-clean frames update
// key_value/cmd_arg. Bad checksums and inter-byte timeouts are reported and counted.
`timescale 1ns/1ps
module uart_cmd_parser #(
  parameter logic [7:0]  SOF         = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] key_value,
  output logic [7:0] cmd_arg,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       timeout_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GET_CMD = 2'd1;
  localparam logic [1:0] ST_GET_ARG = 2'd2;
  localparam logic [1:0] ST_GET_CHK = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       key_q, key_d;
  logic [7:0]       arg_q, arg_d;
  logic [7:0]       cmd_sh_q, cmd_sh_d;
  logic [7:0]       arg_sh_q, arg_sh_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_err_q, timeout_err_d;

  function automatic logic [7:0] chk_sum(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_d         = key_q;
    arg_d         = arg_q;
    cmd_sh_d      = cmd_sh_q;
    arg_sh_d      = arg_sh_q;
    cmd_valid_d   = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    if (rx_valid) begin
      // Any consumed byte restarts the inter-byte timer, so a byte in the expiry cycle wins.
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SOF) state_d = ST_GET_CMD;
        end
        ST_GET_CMD: begin
          cmd_sh_d = rx_data;
          state_d  = ST_GET_ARG;
        end
        ST_GET_ARG: begin
          arg_sh_d = rx_data;
          state_d  = ST_GET_CHK;
        end
        default: begin
          if (rx_data == chk_sum(cmd_sh_q, arg_sh_q)) begin
            key_d       = cmd_sh_q;
            arg_d       = arg_sh_q;
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      timeout_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    err_cnt_d = (frame_err_d || timeout_err_d) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_q         <= 8'h00;
      arg_q         <= 8'h00;
      err_cnt_q     <= 8'h00;
      cmd_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      arg_q         <= arg_d;
      err_cnt_q     <= err_cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Shadows are always written before use in a frame, so they carry no reset.
  always_ff @(posedge clk) begin
    cmd_sh_q <= cmd_sh_d;
    arg_sh_q <= arg_sh_d;
  end

  assign key_value   = key_q;
  assign cmd_arg     = arg_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = (state_q != ST_IDLE);

  a_pulse_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cmd_valid_q, frame_err_q, timeout_err_q}));

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a frame-level model predicts every output pulse,
// and a negedge monitor pops and compares those predictions as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int         T   = 100;
  localparam logic [7:0] SOF = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] key_value, cmd_arg, err_cnt;
  logic       cmd_valid, frame_err, timeout_err, busy;

  uart_cmd_parser #(.SOF(SOF), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_value(key_value), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .timeout_err(timeout_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         kind;   // 0 command, 1 checksum error, 2 timeout
    int         at;
    logic [7:0] key;
    logic [7:0] arg;
    logic [7:0] ec;
  } ev_t;

  ev_t        sb[$];
  int         n_vec = 0;
  int         n_err = 0;

  // Frame-level reference state
  logic [7:0] fb[$];
  int         last_t = 0;
  logic [7:0] mkey = 8'h00, marg = 8'h00, merr = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int at);
    ev_t e;
    if (kind != 0) merr = (merr == 8'hFF) ? merr : merr + 8'd1;
    e.kind = kind; e.at = at; e.key = mkey; e.arg = marg; e.ec = merr;
    sb.push_back(e);
  endfunction

  // A frame in progress dies once T cycles pass with no byte; the error is
  // visible the cycle after the T-th idle cycle.
  function automatic void model_advance(input int t_byte);
    if (fb.size() != 0 && (t_byte - last_t - 1) >= T) begin
      push_ev(2, last_t + T + 1);
      fb.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int t);
    logic [7:0] s;
    if (fb.size() == 0) begin
      if (b == SOF) fb.push_back(b);
    end else begin
      fb.push_back(b);
      if (fb.size() == 4) begin
        s = fb[1] + fb[2];
        if (b == s) begin
          mkey = fb[1];
          marg = fb[2];
          push_ev(0, t + 1);
        end else begin
          push_ev(1, t + 1);
        end
        fb.delete();
      end
    end
    last_t = t;
  endfunction

  // Entry/exit: #1 after a posedge, current cycle not yet driven.
  task automatic send(input logic [7:0] b, input int idle);
    model_advance(cyc + idle);
    repeat (idle) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b, cyc);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] chk, input int idle);
    send(SOF, idle); send(c, idle); send(a, idle); send(chk, idle);
  endtask

  task automatic wait_cyc(input int n);
    model_advance(cyc + n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14)       return $urandom_range(0, 3);
    else if (r == 14) return T - 1;
    else if (r == 15) return T;
    else if (r == 16) return T + $urandom_range(0, 5);
    else              return $urandom_range(4, 20);
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_key"}, 32'(key_value), 32'(mkey));
    check({tag, "_arg"}, 32'(cmd_arg), 32'(marg));
    check({tag, "_errcnt"}, 32'(err_cnt), 32'(merr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"}, 32'(key_value), 0);
    check({tag, "_arg"}, 32'(cmd_arg), 0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_errcnt"}, 32'(err_cnt), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Monitor: every pulse must match the oldest prediction.
  int  mon_kind;
  ev_t mon_e;
  always @(negedge clk) begin
    if (rst_n && (cmd_valid || frame_err || timeout_err)) begin
      mon_kind = cmd_valid ? 0 : (frame_err ? 1 : 2);
      check("pulse_onehot", 32'(int'(cmd_valid) + int'(frame_err) + int'(timeout_err)), 1);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none required", mon_kind, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ev_kind", 32'(mon_kind), 32'(mon_e.kind));
        check("ev_cycle", 32'(cyc), 32'(mon_e.at));
        check("ev_key", 32'(key_value), 32'(mon_e.key));
        check("ev_arg", 32'(cmd_arg), 32'(mon_e.arg));
        check("ev_errcnt", 32'(err_cnt), 32'(mon_e.ec));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, a, k;
    int         r, nb;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Clean frame with spacing, then a bad checksum
    send_frame(8'h12, 8'h34, 8'h46, 10);
    wait_cyc(3);
    check_held("good1");
    check("good1_busy", 32'(busy), 0);
    send_frame(8'h12, 8'h34, 8'h47, 2);
    wait_cyc(3);
    check_held("badchk");
    check("badchk_busy", 32'(busy), 0);

    // Leading junk ignored
    send(8'h55, 1); send(8'h00, 1);
    send_frame(8'h05, 8'h01, 8'h06, 1);
    wait_cyc(3);
    check_held("junk");

    // Timeout after a partial frame, then recovery
    send(SOF, 2); send(8'h03, 0);
    check("partial_busy", 32'(busy), 1);
    send_frame(8'h03, 8'h00, 8'h03, 150);
    wait_cyc(3);
    check_held("after_to");

    // Byte arrives exactly in the expiry cycle
    send(SOF, 1); send(8'h21, 0); send(8'h09, T - 1); send(8'h2A, T - 1);
    wait_cyc(3);
    check_held("expiry");

    // Back-to-back frames, SOF value as CMD data
    send_frame(8'hAA, 8'h10, 8'hBA, 0);
    send_frame(8'h7F, 8'h81, 8'h00, 0);
    send_frame(8'h01, 8'h02, 8'h03, 0);
    wait_cyc(3);
    check_held("b2b");

    // Randomized traffic
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 9);
      c = $urandom_range(0, 255);
      a = $urandom_range(0, 255);
      k = c + a;
      if (r < 2) begin
        send(8'($urandom_range(0, 255)), pick_gap());
      end else if (r < 6) begin
        send(SOF, pick_gap()); send(c, pick_gap()); send(a, pick_gap()); send(k, pick_gap());
      end else if (r < 8) begin
        send(SOF, pick_gap()); send(c, pick_gap()); send(a, pick_gap());
        send(k + 8'($urandom_range(1, 255)), pick_gap());
      end else begin
        nb = $urandom_range(0, 2);
        send(SOF, pick_gap());
        for (int i = 0; i < nb; i++) send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
        wait_cyc(T + 2);
      end
    end
    wait_cyc(T + 5);
    check_held("random");

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_frame(8'(i), 8'h11, 8'(i) + 8'h12, 0);
    wait_cyc(3);
    check("sat_errcnt", 32'(err_cnt), 32'hFF);
    check_held("sat");

    // Reset mid-frame aborts everything
    send(SOF, 0); send(8'h07, 0);
    wait_cyc(2);
    check("pre_rst_pending", 32'(sb.size()), 0);
    rst_n = 1'b0;
    #2;
    check_all_zero("midrst");
    fb.delete(); mkey = 8'h00; marg = 8'h00; merr = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(8'h07, 8'h00, 8'h07, 0);
    wait_cyc(3);
    check_held("post_rst");

    wait_cyc(T + 5);
    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
